// File: rtl/quiz_pkg.sv
// Shared types and limits for the quiz round controller.
// The answer field is 7 bits wide, so the largest answer that can be typed is 127.
package quiz_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_Q  = 3'd1,
    S_WAIT_Q = 3'd2,
    S_ANSWER = 3'd3,
    S_JUDGE  = 3'd4,
    S_SHOW   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam int RES_W      = 7;
  localparam int DIGIT_MAX  = 9;
  localparam int ANSWER_MAX = 127;

  // Widened so that an overflowing entry can be seen and refused instead of wrapping.
  function automatic logic [10:0] append_digit(input logic [RES_W-1:0] val,
                                               input logic [3:0]       d);
    return 11'(val) * 11'd10 + 11'(d);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Countdown prescaler: counts clk cycles while enabled and emits a one-cycle tick
// every CLK_HZ cycles. A synchronous clear restarts the count from zero.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] WRAP = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == WRAP) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == WRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz game sequencer: fetches a question, runs the round countdown, assembles
// the typed answer, judges it, holds the verdict on screen and keeps score.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for the first start after reset
// S_REQ_Q  | new_q_req high for this one cycle; clear answer and verdict
// S_WAIT_Q | waiting for ques_ready; latch result, arm countdown
// S_ANSWER | accepting keys while the seconds count down
// S_JUDGE  | compare the typed answer against the latched result
// S_SHOW   | hold right/wrong for SHOW_CYCLES cycles
// S_DONE   | game over; score frozen until the next start
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int ROUND_SECS  = 10,
  parameter int NUM_ROUNDS  = 10,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             new_q_req,
  input  logic             ques_ready,
  input  logic [RES_W-1:0] result,
  input  logic             kb_valid,
  input  logic [3:0]       kb_digit,
  input  logic             kb_enter,
  input  logic             kb_bksp,
  output logic [RES_W-1:0] kb_result,
  output logic [3:0]       secs_left,
  output logic [3:0]       round_num,
  output logic [3:0]       score,
  output logic             right,
  output logic             wrong,
  output logic             game_over
);

  localparam int                HOLD_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]        SECS_INIT  = 4'(ROUND_SECS);
  localparam logic [3:0]        ROUNDS_MAX = 4'(NUM_ROUNDS);

  state_e            state_q, state_d;
  logic              new_q_req_q, new_q_req_d;
  logic [RES_W-1:0]  kb_result_q, kb_result_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [3:0]        secs_left_q, secs_left_d;
  logic [3:0]        round_num_q, round_num_d;
  logic [3:0]        score_q, score_d;
  logic              right_q, right_d;
  logic              wrong_q, wrong_d;
  logic              game_over_q, game_over_d;
  logic              timed_out_q, timed_out_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [10:0]       appended;
  logic              sec_pulse;

  // The prescaler only runs in ANSWER, so every round starts a full second from zero.
  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != S_ANSWER),
    .en    (state_q == S_ANSWER),
    .tick  (sec_pulse)
  );

  always_comb begin
    state_d     = state_q;
    new_q_req_d = 1'b0;
    kb_result_d = kb_result_q;
    result_d    = result_q;
    secs_left_d = secs_left_q;
    round_num_d = round_num_q;
    score_d     = score_q;
    right_d     = right_q;
    wrong_d     = wrong_q;
    game_over_d = game_over_q;
    timed_out_d = timed_out_q;
    hold_d      = hold_q;
    appended    = append_digit(kb_result_q, kb_digit);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_REQ_Q;
          new_q_req_d = 1'b1;
          score_d     = '0;
          round_num_d = '0;
          game_over_d = 1'b0;
        end
      end
      S_REQ_Q: begin
        kb_result_d = '0;
        right_d     = 1'b0;
        wrong_d     = 1'b0;
        state_d     = S_WAIT_Q;
      end
      S_WAIT_Q: begin
        if (ques_ready) begin
          result_d    = result;
          secs_left_d = SECS_INIT;
          timed_out_d = 1'b0;
          state_d     = S_ANSWER;
        end
      end
      S_ANSWER: begin
        if (sec_pulse) begin
          if (secs_left_q <= 4'd1) begin
            secs_left_d = '0;
            timed_out_d = 1'b1;
            state_d     = S_JUDGE;
          end else begin
            secs_left_d = secs_left_q - 4'd1;
          end
        end
        // A submit on the final tick still counts as answered in time.
        if (kb_valid) begin
          if (kb_enter) begin
            timed_out_d = 1'b0;
            state_d     = S_JUDGE;
          end else if (kb_bksp) begin
            kb_result_d = kb_result_q / 7'd10;
          end else if (kb_digit <= 4'(DIGIT_MAX) && appended <= 11'(ANSWER_MAX)) begin
            kb_result_d = appended[RES_W-1:0];
          end
        end
      end
      S_JUDGE: begin
        if (kb_result_q == result_q && !timed_out_q) begin
          right_d = 1'b1;
          if (score_q < ROUNDS_MAX) score_d = score_q + 4'd1;
        end else begin
          wrong_d = 1'b1;
        end
        if (round_num_q < ROUNDS_MAX) round_num_d = round_num_q + 4'd1;
        hold_d  = HOLD_LOAD;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (hold_q == '0) begin
          if (round_num_q >= ROUNDS_MAX) begin
            state_d     = S_DONE;
            game_over_d = 1'b1;
          end else begin
            state_d     = S_REQ_Q;
            new_q_req_d = 1'b1;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      new_q_req_q <= 1'b0;
      kb_result_q <= '0;
      result_q    <= '0;
      secs_left_q <= '0;
      round_num_q <= '0;
      score_q     <= '0;
      right_q     <= 1'b0;
      wrong_q     <= 1'b0;
      game_over_q <= 1'b0;
      timed_out_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      new_q_req_q <= new_q_req_d;
      kb_result_q <= kb_result_d;
      result_q    <= result_d;
      secs_left_q <= secs_left_d;
      round_num_q <= round_num_d;
      score_q     <= score_d;
      right_q     <= right_d;
      wrong_q     <= wrong_d;
      game_over_q <= game_over_d;
      timed_out_q <= timed_out_d;
      hold_q      <= hold_d;
    end
  end

  assign new_q_req = new_q_req_q;
  assign kb_result = kb_result_q;
  assign secs_left = secs_left_q;
  assign round_num = round_num_q;
  assign score     = score_q;
  assign right     = right_q;
  assign wrong     = wrong_q;
  assign game_over = game_over_q;

endmodule
